ccu_run_controller: RTL

- Sequencer for the context control unit (CCU) of one CGRA processing element.
- Streams host-supplied context words into the CCU context memory, then launches execution at a start context via the CCU load path.
- Holds the CCU enabled until the context counter reaches a halt context, a watchdog expires or the host aborts, then reports completion status and the executed cycle count.

---
 rtl/ccu_ctrl_pkg.sv | 25 ++
 rtl/ccu_run_controller_if.sv | 27 ++
 rtl/ccu_cycle_watchdog.sv | 31 +++
 rtl/ccu_run_controller.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ccu_ctrl_pkg.sv
// Shared types and constants for the CCU run controller and its watchdog.
// Context word layout is {uncond, cond, offset/target}.
package ccu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } ctrl_state_t;

  localparam logic [1:0] STATUS_NONE    = 2'b00;
  localparam logic [1:0] STATUS_HALT    = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b10;
  localparam logic [1:0] STATUS_ABORT   = 2'b11;

  localparam int CTX_UNCOND_BITS = 1;
  localparam int CTX_COND_BITS   = 1;
  localparam int CTX_FLAG_BITS   = CTX_UNCOND_BITS + CTX_COND_BITS;

  function automatic int ctx_word_width(input int addr_width);
    return addr_width + CTX_FLAG_BITS;
  endfunction

endpackage

// File: rtl/ccu_run_controller_if.sv
// Controller-to-CCU bus: context write port, counter load, enable and counter readback.
// The controller is the master; the CCU drives back its context counter.
interface ccu_run_controller_if #(
  parameter int CONTEXT_ADDR_WIDTH = 8
);
  import ccu_ctrl_pkg::*;

  localparam int DW = ctx_word_width(CONTEXT_ADDR_WIDTH);

  logic                          CCU_EN_O;
  logic                          CCU_WR_EN_O;
  logic [CONTEXT_ADDR_WIDTH-1:0] CCU_ADDR_O;
  logic [DW-1:0]                 CCU_DATA_O;
  logic                          CCU_LOAD_EN_O;
  logic [CONTEXT_ADDR_WIDTH-1:0] CCU_CCNT_I;

  modport master (
    output CCU_EN_O, CCU_WR_EN_O, CCU_ADDR_O, CCU_DATA_O, CCU_LOAD_EN_O,
    input  CCU_CCNT_I
  );

  modport slave (
    input  CCU_EN_O, CCU_WR_EN_O, CCU_ADDR_O, CCU_DATA_O, CCU_LOAD_EN_O,
    output CCU_CCNT_I
  );

endinterface

// File: rtl/ccu_cycle_watchdog.sv
// Saturating run-cycle counter with synchronous clear and a look-ahead limit compare.
// expire_next flags the enabled cycle whose increment makes count equal the limit.
module ccu_cycle_watchdog #(
  parameter int CYCLE_CNT_WIDTH = 16
) (
  input  logic                       CLK_I,
  input  logic                       RST_N_I,
  input  logic                       clr,
  input  logic                       en,
  input  logic [CYCLE_CNT_WIDTH-1:0] limit,
  output logic [CYCLE_CNT_WIDTH-1:0] count,
  output logic                       expire_next
);

  logic [CYCLE_CNT_WIDTH-1:0] count_q;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // A zero limit disables the watchdog entirely.
  assign expire_next = en && (limit != '0) && (count_q == (limit - 1'b1));
  assign count       = count_q;

endmodule

// File: rtl/ccu_run_controller.sv
// Sequencer for one PE's CCU: streams context words in, launches at a start context,
// and runs until halt context, watchdog expiry or host abort, then reports status/cycles.
module ccu_run_controller
  import ccu_ctrl_pkg::*;
#(
  parameter int CONTEXT_ADDR_WIDTH = 8,
  parameter int CYCLE_CNT_WIDTH    = 16
) (
  input  logic                                        CLK_I,
  input  logic                                        RST_N_I,
  input  logic                                        CFG_VALID_I,
  output logic                                        CFG_READY_O,
  input  logic [CONTEXT_ADDR_WIDTH-1:0]               CFG_ADDR_I,
  input  logic [CONTEXT_ADDR_WIDTH+CTX_FLAG_BITS-1:0] CFG_DATA_I,
  input  logic                                        START_I,
  output logic                                        START_READY_O,
  input  logic [CONTEXT_ADDR_WIDTH-1:0]               START_ADDR_I,
  input  logic [CONTEXT_ADDR_WIDTH-1:0]               HALT_ADDR_I,
  input  logic [CYCLE_CNT_WIDTH-1:0]                  MAX_CYCLES_I,
  input  logic                                        STALL_I,
  input  logic                                        ABORT_I,
  output logic                                        DONE_O,
  input  logic                                        DONE_ACK_I,
  output logic [1:0]                                  STATUS_O,
  output logic [CYCLE_CNT_WIDTH-1:0]                  CYCLES_O,
  ccu_run_controller_if.master                        ccu
);

  localparam int DW = CONTEXT_ADDR_WIDTH + CTX_FLAG_BITS;

  ctrl_state_t                   state_q;
  logic [CONTEXT_ADDR_WIDTH-1:0] start_addr_q;
  logic [CONTEXT_ADDR_WIDTH-1:0] halt_addr_q;
  logic [CYCLE_CNT_WIDTH-1:0]    max_cycles_q;
  logic [1:0]                    status_q;
  logic                          wr_en_q;
  logic [CONTEXT_ADDR_WIDTH-1:0] wr_addr_q;
  logic [DW-1:0]                 wr_data_q;

  logic                          is_idle;
  logic                          cfg_fire;
  logic                          start_fire;
  logic                          run_en;
  logic                          halt_hit;
  logic                          wd_expire;
  logic [CYCLE_CNT_WIDTH-1:0]    wd_count;

  assign is_idle    = (state_q == IDLE);
  assign cfg_fire   = CFG_VALID_I && is_idle;
  // A pending context write always wins over a launch in the same cycle.
  assign start_fire = START_I && is_idle && !CFG_VALID_I;
  assign run_en     = (state_q == RUN) && !STALL_I;
  // Halt detection is frozen together with the CCU while stalled.
  assign halt_hit   = run_en && (ccu.CCU_CCNT_I == halt_addr_q);

  ccu_cycle_watchdog #(
    .CYCLE_CNT_WIDTH (CYCLE_CNT_WIDTH)
  ) u_watchdog (
    .CLK_I       (CLK_I),
    .RST_N_I     (RST_N_I),
    .clr         (start_fire),
    .en          (run_en),
    .limit       (max_cycles_q),
    .count       (wd_count),
    .expire_next (wd_expire)
  );

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q      <= IDLE;
      start_addr_q <= '0;
      halt_addr_q  <= '0;
      max_cycles_q <= '0;
      status_q     <= STATUS_NONE;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      wr_en_q   <= cfg_fire;
      wr_addr_q <= cfg_fire ? CFG_ADDR_I : '0;
      wr_data_q <= cfg_fire ? CFG_DATA_I : '0;

      unique case (state_q)
        IDLE: begin
          if (start_fire) begin
            start_addr_q <= START_ADDR_I;
            halt_addr_q  <= HALT_ADDR_I;
            max_cycles_q <= MAX_CYCLES_I;
            status_q     <= STATUS_NONE;
            state_q      <= START;
          end
        end
        START: begin
          if (ABORT_I) begin
            status_q <= STATUS_ABORT;
            state_q  <= DONE;
          end else begin
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (ABORT_I) begin
            status_q <= STATUS_ABORT;
            state_q  <= DONE;
          end else if (halt_hit) begin
            status_q <= STATUS_HALT;
            state_q  <= DONE;
          end else if (wd_expire) begin
            status_q <= STATUS_TIMEOUT;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (DONE_ACK_I) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign CFG_READY_O       = is_idle;
  assign START_READY_O     = is_idle && !CFG_VALID_I;
  assign DONE_O            = (state_q == DONE);
  assign STATUS_O          = status_q;
  assign CYCLES_O          = wd_count;

  assign ccu.CCU_EN_O      = (state_q == START) || run_en;
  assign ccu.CCU_LOAD_EN_O = (state_q == START);
  assign ccu.CCU_WR_EN_O   = wr_en_q;
  assign ccu.CCU_ADDR_O    = (state_q == START) ? start_addr_q : wr_addr_q;
  assign ccu.CCU_DATA_O    = wr_data_q;

endmodule
